// File: rtl/pipe_ctrl_chain_if.sv
// Interface bundling the ID-side handshake, hazard-unit masks and the
// stage taps / status outputs of the control-word pipeline chain.
interface pipe_ctrl_chain_if #(
    parameter int WIDTH   = 16,
    parameter int STAGES  = 3,
    parameter int COUNT_W = 16
);
    logic                          in_valid;
    logic [WIDTH-1:0]              in_word;
    logic                          in_ready;
    logic [STAGES-1:0]             hold_mask;
    logic [STAGES-1:0]             flush_mask;
    logic [STAGES-1:0]             stage_valid;
    logic [STAGES*WIDTH-1:0]       stage_word;
    logic                          out_valid;
    logic [WIDTH-1:0]              out_word;
    logic [$clog2(STAGES+1)-1:0]   occupancy;
    logic [COUNT_W-1:0]            retire_count;

    // ID stage / hazard unit side
    modport master (
        output in_valid, in_word, hold_mask, flush_mask,
        input  in_ready, stage_valid, stage_word, out_valid, out_word,
               occupancy, retire_count
    );

    // Pipeline chain side
    modport slave (
        input  in_valid, in_word, hold_mask, flush_mask,
        output in_ready, stage_valid, stage_word, out_valid, out_word,
               occupancy, retire_count
    );
endinterface

// File: rtl/pipe_ctrl_chain.sv
// Parametrised chain of control-word pipeline registers (EX .. WB).
// Each stage has a valid bit, per-stage hold and flush, and bubbles
// collapse because an empty stage is never frozen by its downstream.
module pipe_ctrl_chain #(
    parameter int               WIDTH    = 16,
    parameter int               STAGES   = 3,
    parameter logic [WIDTH-1:0] NOP_WORD = '0,
    parameter int               COUNT_W  = 16
) (
    input logic            clk,
    input logic            reset,
    pipe_ctrl_chain_if.slave bus
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0]       valid_q;
    logic [WIDTH-1:0]        word_q [STAGES];
    logic [OCC_W-1:0]        occ_q;
    logic [COUNT_W-1:0]      retire_q;

    logic [STAGES-1:0]       frozen;
    logic [STAGES-1:0]       next_valid;
    logic [WIDTH-1:0]        next_word [STAGES];
    logic [OCC_W-1:0]        next_occ;
    logic                    retire_fire;
    logic [STAGES*WIDTH-1:0] word_flat;

    // Backpressure walks upstream from the last stage, but only through occupied stages
    always_comb begin
        logic down;
        frozen = '0;
        down = bus.hold_mask[STAGES-1];
        frozen[STAGES-1] = down;
        for (int i = STAGES - 2; i >= 0; i--) begin
            down = bus.hold_mask[i] | (valid_q[i] & down);
            frozen[i] = down;
        end
    end

    // Next contents of every stage: flush beats hold beats load-from-source
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            next_valid[i] = 1'b0;
            next_word[i]  = NOP_WORD;
        end

        if (!bus.flush_mask[0]) begin
            if (frozen[0]) begin
                next_valid[0] = valid_q[0];
                next_word[0]  = word_q[0];
            end else begin
                next_valid[0] = bus.in_valid;
                next_word[0]  = bus.in_valid ? bus.in_word : NOP_WORD;
            end
        end

        for (int i = 1; i < STAGES; i++) begin
            if (!bus.flush_mask[i]) begin
                if (frozen[i]) begin
                    next_valid[i] = valid_q[i];
                    next_word[i]  = word_q[i];
                end else if (!frozen[i-1]) begin
                    next_valid[i] = valid_q[i-1];
                    next_word[i]  = word_q[i-1];
                end
            end
        end
    end

    // Occupancy is the popcount of the valid bits about to be registered
    always_comb begin
        next_occ = '0;
        for (int i = 0; i < STAGES; i++) begin
            next_occ = next_occ + OCC_W'(next_valid[i]);
        end
    end

    assign retire_fire = valid_q[STAGES-1] & ~bus.hold_mask[STAGES-1];

    // Stage registers, occupancy and the saturating retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            occ_q    <= '0;
            retire_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                word_q[i] <= NOP_WORD;
            end
        end else begin
            valid_q <= next_valid;
            occ_q   <= next_occ;
            for (int i = 0; i < STAGES; i++) begin
                word_q[i] <= next_word[i];
            end
            if (retire_fire && (retire_q != {COUNT_W{1'b1}})) begin
                retire_q <= retire_q + COUNT_W'(1);
            end
        end
    end

    // Flatten the per-stage words onto the tap bus
    always_comb begin
        word_flat = '0;
        for (int i = 0; i < STAGES; i++) begin
            word_flat[i*WIDTH +: WIDTH] = word_q[i];
        end
    end

    assign bus.in_ready     = ~frozen[0];
    assign bus.stage_valid  = valid_q;
    assign bus.stage_word   = word_flat;
    assign bus.out_valid    = valid_q[STAGES-1];
    assign bus.out_word     = word_q[STAGES-1];
    assign bus.occupancy    = occ_q;
    assign bus.retire_count = retire_q;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed bench for pipe_ctrl_chain: two instances (16-bit and 4-bit
// retire counters) share one stimulus stream.
module tb_pipe_ctrl_chain;
    localparam logic [15:0] NOP = 16'hF00F;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_word;
    logic [2:0]  hold_mask;
    logic [2:0]  flush_mask;

    int checks = 0;
    int errors = 0;

    pipe_ctrl_chain_if #(.WIDTH(16), .STAGES(3), .COUNT_W(16)) bus16 ();
    pipe_ctrl_chain_if #(.WIDTH(16), .STAGES(3), .COUNT_W(4))  bus4 ();

    assign bus16.in_valid   = in_valid;
    assign bus16.in_word    = in_word;
    assign bus16.hold_mask  = hold_mask;
    assign bus16.flush_mask = flush_mask;
    assign bus4.in_valid    = in_valid;
    assign bus4.in_word     = in_word;
    assign bus4.hold_mask   = hold_mask;
    assign bus4.flush_mask  = flush_mask;

    pipe_ctrl_chain #(.WIDTH(16), .STAGES(3), .NOP_WORD(NOP), .COUNT_W(16)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16)
    );

    pipe_ctrl_chain #(.WIDTH(16), .STAGES(3), .NOP_WORD(NOP), .COUNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkStages(input string tag, input logic [2:0] v,
                               input logic [15:0] w0, input logic [15:0] w1,
                               input logic [15:0] w2);
        checkOutput({tag, ".valid"}, 64'(bus16.stage_valid), 64'(v));
        checkOutput({tag, ".w0"}, 64'(bus16.stage_word[15:0]), 64'(w0));
        checkOutput({tag, ".w1"}, 64'(bus16.stage_word[31:16]), 64'(w1));
        checkOutput({tag, ".w2"}, 64'(bus16.stage_word[47:32]), 64'(w2));
        checkOutput({tag, ".out_valid"}, 64'(bus16.out_valid), 64'(v[2]));
        checkOutput({tag, ".out_word"}, 64'(bus16.out_word), 64'(w2));
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] w,
                                 input logic [2:0] hold, input logic [2:0] flush);
        in_valid   = v;
        in_word    = w;
        hold_mask  = hold;
        flush_mask = flush;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 16'h0000, 3'b000, 3'b000);
        step();
        step();

        // Reset state
        checkStages("reset", 3'b000, NOP, NOP, NOP);
        checkOutput("reset.occ", 64'(bus16.occupancy), 64'd0);
        checkOutput("reset.retire", 64'(bus16.retire_count), 64'd0);
        checkOutput("reset.in_ready", 64'(bus16.in_ready), 64'd1);
        reset = 1'b0;

        // Three back-to-back words, no hold or flush
        $display("[TB] streaming 1111/2222/3333");
        applyStimulus(1'b1, 16'h1111, 3'b000, 3'b000);
        checkOutput("s1.in_ready", 64'(bus16.in_ready), 64'd1);
        step();
        checkStages("s1.e1", 3'b001, 16'h1111, NOP, NOP);
        checkOutput("s1.e1.occ", 64'(bus16.occupancy), 64'd1);
        applyStimulus(1'b1, 16'h2222, 3'b000, 3'b000);
        step();
        checkStages("s1.e2", 3'b011, 16'h2222, 16'h1111, NOP);
        applyStimulus(1'b1, 16'h3333, 3'b000, 3'b000);
        checkOutput("s1.e3.in_ready", 64'(bus16.in_ready), 64'd1);
        step();
        checkStages("s1.e3", 3'b111, 16'h3333, 16'h2222, 16'h1111);
        checkOutput("s1.e3.occ", 64'(bus16.occupancy), 64'd3);
        checkOutput("s1.e3.retire", 64'(bus16.retire_count), 64'd0);
        applyStimulus(1'b0, 16'h0000, 3'b000, 3'b000);
        step();
        checkStages("s1.e4", 3'b110, NOP, 16'h3333, 16'h2222);
        checkOutput("s1.e4.occ", 64'(bus16.occupancy), 64'd2);
        checkOutput("s1.e4.retire", 64'(bus16.retire_count), 64'd1);
        step();
        checkStages("s1.e5", 3'b100, NOP, NOP, 16'h3333);
        checkOutput("s1.e5.retire", 64'(bus16.retire_count), 64'd2);
        step();
        checkStages("s1.e6", 3'b000, NOP, NOP, NOP);
        checkOutput("s1.e6.occ", 64'(bus16.occupancy), 64'd0);
        checkOutput("s1.e6.retire", 64'(bus16.retire_count), 64'd3);

        // Fill with A/B/C, then hold the last stage for two cycles
        $display("[TB] hold last stage");
        applyStimulus(1'b1, 16'h000C, 3'b000, 3'b000);
        step();
        applyStimulus(1'b1, 16'h000B, 3'b000, 3'b000);
        step();
        applyStimulus(1'b1, 16'h000A, 3'b000, 3'b000);
        step();
        checkStages("s2.full", 3'b111, 16'h000A, 16'h000B, 16'h000C);
        applyStimulus(1'b1, 16'h000D, 3'b100, 3'b000);
        checkOutput("s2.h1.in_ready", 64'(bus16.in_ready), 64'd0);
        step();
        checkStages("s2.h1", 3'b111, 16'h000A, 16'h000B, 16'h000C);
        checkOutput("s2.h1.retire", 64'(bus16.retire_count), 64'd3);
        checkOutput("s2.h2.in_ready", 64'(bus16.in_ready), 64'd0);
        step();
        checkStages("s2.h2", 3'b111, 16'h000A, 16'h000B, 16'h000C);
        checkOutput("s2.h2.retire", 64'(bus16.retire_count), 64'd3);
        applyStimulus(1'b1, 16'h000D, 3'b000, 3'b000);
        checkOutput("s2.rel.in_ready", 64'(bus16.in_ready), 64'd1);
        step();
        checkStages("s2.rel", 3'b111, 16'h000D, 16'h000A, 16'h000B);
        checkOutput("s2.rel.retire", 64'(bus16.retire_count), 64'd4);

        // Refill to A/B/C, then hold stage 0 only
        $display("[TB] hold first stage");
        applyStimulus(1'b1, 16'h000C, 3'b000, 3'b000);
        step();
        applyStimulus(1'b1, 16'h000B, 3'b000, 3'b000);
        step();
        applyStimulus(1'b1, 16'h000A, 3'b000, 3'b000);
        step();
        checkStages("s3.full", 3'b111, 16'h000A, 16'h000B, 16'h000C);
        checkOutput("s3.full.retire", 64'(bus16.retire_count), 64'd7);
        applyStimulus(1'b1, 16'h000D, 3'b001, 3'b000);
        checkOutput("s3.in_ready", 64'(bus16.in_ready), 64'd0);
        step();
        checkStages("s3.h", 3'b101, 16'h000A, NOP, 16'h000B);
        checkOutput("s3.h.retire", 64'(bus16.retire_count), 64'd8);
        checkOutput("s3.h.occ", 64'(bus16.occupancy), 64'd2);

        // Bubble in stage 1 collapses while stage 2 is held
        $display("[TB] bubble collapse");
        applyStimulus(1'b1, 16'h000E, 3'b100, 3'b000);
        checkOutput("s4.in_ready", 64'(bus16.in_ready), 64'd1);
        step();
        checkStages("s4", 3'b111, 16'h000E, 16'h000A, 16'h000B);
        checkOutput("s4.retire", 64'(bus16.retire_count), 64'd8);
        checkOutput("s4.occ", 64'(bus16.occupancy), 64'd3);

        // Refill to A/B/C, then flush stages 0 and 1 while accepting D
        $display("[TB] flush");
        applyStimulus(1'b1, 16'h000C, 3'b000, 3'b000);
        step();
        applyStimulus(1'b1, 16'h000B, 3'b000, 3'b000);
        step();
        applyStimulus(1'b1, 16'h000A, 3'b000, 3'b000);
        step();
        checkStages("s5.full", 3'b111, 16'h000A, 16'h000B, 16'h000C);
        checkOutput("s5.full.retire", 64'(bus16.retire_count), 64'd11);
        applyStimulus(1'b1, 16'h000D, 3'b000, 3'b011);
        checkOutput("s5.f.in_ready", 64'(bus16.in_ready), 64'd1);
        step();
        checkStages("s5.f", 3'b100, NOP, NOP, 16'h000B);
        checkOutput("s5.f.retire", 64'(bus16.retire_count), 64'd12);
        checkOutput("s5.f.occ", 64'(bus16.occupancy), 64'd1);

        // Refill to C/B/A, then flush and hold the last stage together
        applyStimulus(1'b1, 16'h000A, 3'b000, 3'b000);
        step();
        checkOutput("s5.r1.retire", 64'(bus16.retire_count), 64'd13);
        applyStimulus(1'b1, 16'h000B, 3'b000, 3'b000);
        step();
        applyStimulus(1'b1, 16'h000C, 3'b000, 3'b000);
        step();
        checkStages("s5.r3", 3'b111, 16'h000C, 16'h000B, 16'h000A);
        applyStimulus(1'b1, 16'h000D, 3'b100, 3'b100);
        checkOutput("s5.fh.in_ready", 64'(bus16.in_ready), 64'd0);
        step();
        checkStages("s5.fh", 3'b011, 16'h000C, 16'h000B, NOP);
        checkOutput("s5.fh.retire", 64'(bus16.retire_count), 64'd13);
        checkOutput("s5.fh.occ", 64'(bus16.occupancy), 64'd2);

        // Stream 20 words: the 4-bit counter saturates, the 16-bit one keeps counting
        $display("[TB] saturation stream");
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b1, 16'h0100 + 16'(k), 3'b000, 3'b000);
            step();
            if (k == 3) begin
                checkOutput("s6.k3.r16", 64'(bus16.retire_count), 64'd15);
                checkOutput("s6.k3.r4", 64'(bus4.retire_count), 64'd15);
            end
            if (k == 4) begin
                checkOutput("s6.k4.r16", 64'(bus16.retire_count), 64'd16);
                checkOutput("s6.k4.r4", 64'(bus4.retire_count), 64'd15);
            end
        end
        checkStages("s6.end", 3'b111, 16'h0114, 16'h0113, 16'h0112);
        checkOutput("s6.end.r16", 64'(bus16.retire_count), 64'd32);
        checkOutput("s6.end.r4", 64'(bus4.retire_count), 64'd15);
        checkOutput("s6.end.occ4", 64'(bus4.occupancy), 64'd3);

        // Reset mid-stream wins over a valid input word
        reset = 1'b1;
        applyStimulus(1'b1, 16'h5555, 3'b000, 3'b000);
        step();
        checkStages("s6.rst", 3'b000, NOP, NOP, NOP);
        checkOutput("s6.rst.r16", 64'(bus16.retire_count), 64'd0);
        checkOutput("s6.rst.r4", 64'(bus4.retire_count), 64'd0);
        checkOutput("s6.rst.occ", 64'(bus16.occupancy), 64'd0);
        checkOutput("s6.rst.in_ready", 64'(bus16.in_ready), 64'd1);
        reset = 1'b0;
        applyStimulus(1'b0, 16'h0000, 3'b000, 3'b000);
        step();
        checkStages("s6.post", 3'b000, NOP, NOP, NOP);
        checkOutput("s6.post.r4", 64'(bus4.retire_count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_chain.md
Name: pipe_ctrl_chain

Overview:
Parametrised pipeline-register chain that carries the decoded control word from ID through EX/MEM/WB-style stages. It generalises fixed per-stage control registers into STAGES identical stages. Each stage has a valid bit, per-stage hold (stall) and flush (bubble insertion), bubble collapse into empty slots, and an in_valid/in_ready handshake at the ID side. It also exposes stage taps, an occupancy count and a saturating retire counter for the hazard unit and the testbench.

Parameters:
WIDTH, 16, width of the control word carried per stage (S, alu_op, load, RF_enable, size, B, BL, shift_AM, ...).
STAGES, 3, number of pipeline stages after ID (stage 0 = EX, stage STAGES-1 = last/WB); legal range 2..8.
NOP_WORD, 0, word loaded into any stage holding a bubble.
COUNT_W, 16, width of retire_count.

Ports:
clk  input  1  clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high.
in_valid  input  1  ID presents a valid control word.
in_word  input  WIDTH  control word from ID; ignored when in_valid=0.
in_ready  output  1  stage 0 accepts this cycle; combinational, equals ~frozen[0].
hold_mask  input  STAGES  bit i: stage i keeps its contents this cycle.
flush_mask  input  STAGES  bit i: stage i becomes a bubble at this edge.
stage_valid  output  STAGES  registered valid bit per stage.
stage_word  output  STAGES*WIDTH  registered word per stage; stage i occupies bits [i*WIDTH +: WIDTH].
out_valid  output  1  equals stage_valid[STAGES-1].
out_word  output  WIDTH  equals word of stage STAGES-1.
occupancy  output  $clog2(STAGES+1)  registered popcount of stage_valid.
retire_count  output  COUNT_W  saturating count of retired words.

Behaviour:
- Reset: has priority over all other inputs. Clears every stage_valid, sets every stage word to NOP_WORD, and clears occupancy and retire_count. in_ready is then 1, provided hold_mask[0]=0.
- frozen[STAGES-1] = hold_mask[STAGES-1].
- frozen[i] for i<STAGES-1 = hold_mask[i] | (stage_valid[i] & frozen[i+1]).
- Backpressure therefore propagates upstream only through occupied stages. An empty stage is never frozen by downstream, so bubbles collapse.
- Next state of stage i, in priority order:
  - flush_mask[i]=1: valid<=0, word<=NOP_WORD. This holds even if frozen[i]. The flush does not alter any frozen[] term, so upstream stages still hold this cycle.
  - frozen[i]=1: keep valid and word.
  - Otherwise, stage i loads from its source:
    - i=0: valid<=in_valid, word<=in_valid ? in_word : NOP_WORD.
    - i>0, frozen[i-1]=0: valid<=stage_valid[i-1], word<=old word of stage i-1.
    - i>0, frozen[i-1]=1: valid<=0, word<=NOP_WORD (bubble inserted).
- Flushing stage i discards whatever would have entered it. It does not affect the old content of stage i, which still moves to stage i+1 whenever stage i is not frozen.
- Handshake: a word is accepted when in_valid & in_ready at the edge. When in_ready=0, ID must hold in_word stable; nothing is consumed. If in_valid=1 and flush_mask[0]=1 while in_ready=1, the word counts as accepted and is discarded.
- Latency: an accepted word with no holds or flushes appears at out_valid exactly STAGES edges after acceptance.
- Retire: fires when stage_valid[STAGES-1] & ~hold_mask[STAGES-1] at an edge, whether or not flush_mask[STAGES-1] is set. retire_count increments by 1 on a fire and saturates at 2^COUNT_W-1; it never wraps.
- occupancy is computed from the next-state valid bits and registered together with them.
- All outputs except in_ready are registered. No combinational path exists from in_word to any output.

Test Plan:
1. Reset, then STAGES=3, WIDTH=16, words 0x1111/0x2222/0x3333 on consecutive cycles, no hold/flush -> out_word shows 0x1111, 0x2222, 0x3333 on cycles 3, 4, 5 after each acceptance; occupancy peaks at 3; retire_count=3; in_ready stays 1.
2. Pipe full (0xA/0xB/0xC in stages 0/1/2), hold_mask=3'b100 for 2 cycles, in_valid=1 with 0xD -> all stages unchanged, in_ready=0, retire_count unchanged; on release, 0xC retires and 0xD enters stage 0.
3. Same full pipe, hold_mask=3'b001 for 1 cycle -> stage0 keeps 0xA, stage1=bubble (NOP_WORD, valid 0), stage2=0xB, 0xC retires, in_ready=0.
4. Bubble collapse: stage1 empty, stage2 valid, hold_mask=3'b100, stage0=0xA, in_word=0xE -> stage1=0xA, stage0=0xE, in_ready=1, stage2 unchanged.
5. Flush: stages 0xA/0xB/0xC, in 0xD accepted, flush_mask=3'b011 -> stage0=NOP, stage1=NOP, stage2=0xB, 0xC retired, occupancy=1. Also flush_mask=3'b100 with hold_mask=3'b100 -> stage2=NOP, stages 0 and 1 held, retire_count unchanged (hold_mask[2]=1 means no retire fire).
6. COUNT_W=4, stream 20 words through -> retire_count saturates at 15. Assert reset mid-stream -> next cycle all valid=0, words=NOP_WORD, retire_count=0.
